// File: rtl/keypoint_merge_scheduler.sv
// keypoint_merge_scheduler: merges two raster-ordered keypoint SRAM lists into one tagged valid/ready stream.
module keypoint_merge_scheduler #(
   parameter int ADDR_W = 11,
   parameter int KP_W   = 19
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [ADDR_W:0]   kp1_count_i,
   input  logic [ADDR_W:0]   kp2_count_i,
   output logic [ADDR_W-1:0] kp1_addr_o,
   input  logic [KP_W-1:0]   kp1_dout_i,
   output logic [ADDR_W-1:0] kp2_addr_o,
   input  logic [KP_W-1:0]   kp2_dout_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [KP_W-1:0]   out_kp_o,
   output logic              out_layer_o,
   output logic              out_last_o,
   output logic              busy_o,
   output logic              done_o
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH   = 3'd1;
   localparam logic [2:0] S_PRESENT = 3'd2;
   localparam logic [2:0] S_REFILL  = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;
   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   logic [2:0]        state_q, state_d;
   logic [ADDR_W:0]   rem1_q, rem1_d, rem2_q, rem2_d;
   logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
   logic [KP_W-1:0]   h1_q, h1_d, h2_q, h2_d;
   logic              v1_q, v1_d, v2_q, v2_d;
   logic              present, sel2, last, cap1, cap2;

   function automatic logic [ADDR_W:0] clamp(input logic [ADDR_W:0] c);
      return (c > DEPTH) ? DEPTH : c;
   endfunction

   assign present = state_q == S_PRESENT;
   // heads are untouched between PRESENT and REFILL, so sel2 also names the list to refill
   assign sel2    = !(v1_q && (!v2_q || h1_q <= h2_q));
   assign last    = rem1_q == '0 && rem2_q == '0 && (v1_q ^ v2_q);
   assign cap1    = (state_q == S_FETCH || (state_q == S_REFILL && !sel2)) && rem1_q != '0;
   assign cap2    = (state_q == S_FETCH || (state_q == S_REFILL && sel2)) && rem2_q != '0;

   always_comb begin
      state_d = state_q;
      rem1_d  = rem1_q;
      rem2_d  = rem2_q;
      addr1_d = addr1_q;
      addr2_d = addr2_q;
      h1_d    = h1_q;
      h2_d    = h2_q;
      v1_d    = v1_q;
      v2_d    = v2_q;
      case (state_q)
         S_IDLE: if (start_i) begin
            rem1_d  = clamp(kp1_count_i);
            rem2_d  = clamp(kp2_count_i);
            state_d = (kp1_count_i == '0 && kp2_count_i == '0) ? S_DONE : S_FETCH;
         end
         S_FETCH:   state_d = S_PRESENT;
         S_PRESENT: if (out_ready_i) state_d = last ? S_DONE : S_REFILL;
         S_REFILL: begin
            state_d = S_PRESENT;
            if (!sel2 && rem1_q == '0) v1_d = 1'b0;
            if (sel2 && rem2_q == '0) v2_d = 1'b0;
         end
         S_DONE: begin
            state_d = S_IDLE;
            addr1_d = '0;
            addr2_d = '0;
            v1_d    = 1'b0;
            v2_d    = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
      if (cap1) begin
         h1_d    = kp1_dout_i;
         v1_d    = 1'b1;
         addr1_d = addr1_q + 1'b1;
         rem1_d  = rem1_q - 1'b1;
      end
      if (cap2) begin
         h2_d    = kp2_dout_i;
         v2_d    = 1'b1;
         addr2_d = addr2_q + 1'b1;
         rem2_d  = rem2_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rem1_q  <= '0;
         rem2_q  <= '0;
         addr1_q <= '0;
         addr2_q <= '0;
         h1_q    <= '0;
         h2_q    <= '0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rem1_q  <= rem1_d;
         rem2_q  <= rem2_d;
         addr1_q <= addr1_d;
         addr2_q <= addr2_d;
         h1_q    <= h1_d;
         h2_q    <= h2_d;
         v1_q    <= v1_d;
         v2_q    <= v2_d;
      end
   end

   assign kp1_addr_o  = addr1_q;
   assign kp2_addr_o  = addr2_q;
   assign out_valid_o = present;
   assign out_kp_o    = present ? (sel2 ? h2_q : h1_q) : '0;
   assign out_layer_o = present && sel2;
   assign out_last_o  = present && last;
   assign busy_o      = state_q != S_IDLE;
   assign done_o      = state_q == S_DONE;
endmodule
